uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- UART receiver that recovers serial frames from the `rx` line, using the one-cycle 16x oversampling tick from the UART baud-rate generator (`s_tick`).
- Frame format: start bit, DBIT data bits LSB-first, optional parity bit, stop bit(s).
- Presents each received word on `dout` with a one-clock `rx_done_tick` strobe and per-frame error flags.
- Sits between the external serial pin and the receive FIFO of the UART.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..8.
- SB_TICK, 16, oversampling ticks for the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal range 16..32.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- s_tick  input  1  one-clk-wide oversampling tick at 16x the baud rate.
- dout  output  8  received word, LSB-aligned; bits above DBIT-1 are 0.
- rx_done_tick  output  1  one-clk strobe: frame complete, dout and flags valid.
- frame_err  output  1  stop bit sampled low on the last completed frame.
- parity_err  output  1  parity mismatch on the last completed frame; always 0 when PARITY_EN = 0.

Behaviour:
- Reset values:
  - dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0.
  - State = IDLE; tick counter s = 0; bit counter n = 0; shift register = 0.
  - Both synchronizer flops = 1.
- Input sync:
  - `rx` passes through 2 flops to form `rx_s`; all decisions use `rx_s`.
  - Adds 2 clk latency.
- Counters: s is 5 bits and increments only on cycles with s_tick = 1. n is 3 bits.
- State machine; every transition below except out of IDLE and WAIT_HIGH requires s_tick = 1:
  - IDLE: if rx_s = 0, go to START with s = 0. No s_tick required.
  - START:
    - At s = 7 (mid start bit): rx_s = 0 -> DATA with s = 0, n = 0.
    - At s = 7 with rx_s = 1: glitch; go to IDLE with no strobe.
    - Otherwise s++.
  - DATA:
    - At s = 15: s = 0; shift rx_s into the shift register MSB side, right-shifting, so the LSB-first stream lands in DBIT-1:0.
    - If n = DBIT-1: go to PARITY when PARITY_EN = 1, else STOP. Otherwise n++.
  - PARITY:
    - At s = 15: s = 0.
    - Compute perr = (XOR of data bits XOR rx_s) != PARITY_ODD, then go to STOP.
  - STOP: at s = SB_TICK-1, the frame completes:
    - rx_done_tick = 1 for exactly one clk.
    - dout and the error flags update in the same clk as the strobe.
    - frame_err = ~rx_s; parity_err = perr.
    - Next state: IDLE if rx_s = 1, else WAIT_HIGH.
  - WAIT_HIGH (break/framing recovery): stay until rx_s = 1, then go to IDLE. A held-low line produces exactly one frame_err frame, not repeated frames.
- Output hold:
  - dout, frame_err and parity_err hold until the next completed frame.
  - A false start does not change any output.
- Strobe latency: rx_done_tick asserts on the clk after the final stop-period s_tick is registered.
- s_tick absent: the FSM stalls in its current state, except for the IDLE->START and WAIT_HIGH->IDLE transitions.
- Back-to-back frames: a start edge seen in the clk after STOP->IDLE is accepted; no extra idle time is required.
- Reset mid-frame: immediate return to reset values; no strobe is issued; the partial word is discarded.
- `rx` changes on a non-tick cycle are ignored except in IDLE and WAIT_HIGH.

Test Plan:
- Testbench conditions for all scenarios: s_tick every 4 clk; DBIT = 8; SB_TICK = 16. One bit time = 64 clk.
- Scenario 1: send 0xA5 with a stop bit of 1 -> exactly one rx_done_tick; dout = 0xA5, frame_err = 0, parity_err = 0; strobe in the clk after the 16th stop tick.
- Scenario 2: rx low for 3 ticks, then high (glitch) -> no rx_done_tick; dout keeps its previous value 0xA5; FSM back in IDLE.
- Scenario 3: send 0x3C with the stop bit forced low, then hold rx low for 40 bit times -> exactly one strobe with dout = 0x3C and frame_err = 1; no further strobes until rx returns high, after which 0x01 is received cleanly with frame_err = 0.
- Scenario 4: PARITY_EN = 1, PARITY_ODD = 0; send 0x37 with parity bit 1 -> parity_err = 0. Send 0x37 with parity bit 0 -> parity_err = 1 and dout = 0x37.
- Scenario 5: assert reset during data bit 4 of 0xFF, release, then send 0x5A -> no strobe for the aborted frame; the next strobe has dout = 0x5A.
- Scenario 6: send 0x00, 0xFF and 0x81 back-to-back with a single stop bit each -> three strobes in order with correct data, no errors, and strobes spaced 640 clk apart.

Source files
------------

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//   UART receiver with 16x oversampling. It recovers frames made of a start
//   bit, DBIT data bits sent LSB first, an optional parity bit and a stop
//   period. Each completed frame is presented on dout, together with its
//   error flags and a one-clock rx_done_tick strobe.
//
// Parameters
//   DBIT       data bits per frame (5..8)
//   SB_TICK    oversampling ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2)
//   PARITY_EN  1 = a parity bit follows the data bits
//   PARITY_ODD 1 = odd parity, 0 = even parity
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   s_tick       one-clock oversampling tick at 16x the baud rate
//   dout         received word, LSB aligned, upper bits zero
//   rx_done_tick one-clock strobe: frame complete, dout and flags valid
//   frame_err    stop bit sampled low on the last completed frame
//   parity_err   parity mismatch on the last completed frame
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned SW = 5;  // tick counter width
  localparam int unsigned NW = 3;  // bit counter width
  localparam int unsigned OW = 8;  // output word width

  localparam logic [SW-1:0] START_MID = SW'(7);
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_shift;
  logic            r_perr;
  logic            r_sync1;
  logic            r_sync2;
  logic [OW-1:0]   r_dout;
  logic            r_done;
  logic            r_frame_err;
  logic            r_parity_err;
  logic            w_rx_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Frame state machine. Only IDLE and WAIT_HIGH react without s_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_dout       <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_s     <= '0;
          end
        end

        // Re-check the line in the middle of the start bit to reject glitches.
        S_START: begin
          if (s_tick) begin
            if (r_s == START_MID) begin
              r_s <= '0;
              if (!w_rx_s) begin
                r_state <= S_DATA;
                r_n     <= '0;
                r_perr  <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        // Sample mid-bit; shifting in at the top leaves the LSB-first word aligned.
        S_DATA: begin
          if (s_tick) begin
            if (r_s == BIT_LAST) begin
              r_s     <= '0;
              r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
              if (r_n == N_LAST) begin
                r_state <= PARITY_EN ? S_PARITY : S_STOP;
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        S_PARITY: begin
          if (s_tick) begin
            if (r_s == BIT_LAST) begin
              r_s     <= '0;
              r_perr  <= ((^r_shift) ^ w_rx_s) != PARITY_ODD;
              r_state <= S_STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        // Frame completes at the end of the stop period; publish word and flags.
        S_STOP: begin
          if (s_tick) begin
            if (r_s == STOP_LAST) begin
              r_s          <= '0;
              r_done       <= 1'b1;
              r_dout       <= OW'(r_shift);
              r_frame_err  <= ~w_rx_s;
              r_parity_err <= r_perr;
              r_state      <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        // A line held low (break) yields one errored frame, then waits for idle.
        S_WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_frame_err;
  assign parity_err   = r_parity_err;

endmodule
